// File: rtl/seq_word_serializer.sv
// rtl/seq_word_serializer.sv - MSB-first word serializer with a one-word pending buffer
module seq_word_serializer #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             word_done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             pend_full_q, pend_full_d;
  logic             alive_q;
  logic             load_fire;

  // alive_q keeps load_ready low until the first edge after reset release
  assign load_ready = alive_q && !pend_full_q;
  assign load_fire  = load_valid && load_ready;
  assign ser_out    = (state_q == SHIFT) ? shreg_q[WIDTH-1] : IDLE_BIT;
  assign ser_valid  = (state_q == SHIFT);
  assign word_done  = (state_q == SHIFT) && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    cnt_d       = cnt_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    case (state_q)
      IDLE: begin
        pend_full_d = 1'b0;
        if (load_fire) begin
          shreg_d = load_data;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != LAST) begin
          shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
          cnt_d   = cnt_q + 1'b1;
          if (load_fire) begin
            pend_d      = load_data;
            pend_full_d = 1'b1;
          end
        end else if (pend_full_q) begin
          shreg_d     = pend_q;
          pend_full_d = 1'b0;
          cnt_d       = '0;
        end else if (load_fire) begin
          // Direct reload keeps the stream gapless without touching pend
          shreg_d = load_data;
          cnt_d   = '0;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      cnt_q       <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      alive_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      alive_q     <= 1'b1;
    end
  end

endmodule

// File: doc/seq_word_serializer.md
# seq_word_serializer

Parallel-to-serial front end of the sequence-detection path: accepts WIDTH-bit words over a valid/ready handshake and emits them MSB-first, one bit per clock, on `ser_out`, which drives the serial `in` input of the sequence detector stage. A one-word pending buffer allows back-to-back words to stream with no idle bit between them. `ser_valid` and `word_done` mark live bits and word boundaries for the detector and the bench.

## Interface
- WIDTH, 8, word length in bits; legal range is WIDTH ≥ 2.
- IDLE_BIT, 1'b0, value driven on `ser_out` when no word is being shifted.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- load_valid  input  1  `load_data` is offered this cycle.
- load_data  input  WIDTH  word to serialize; bit WIDTH-1 is sent first.
- load_ready  output  1  block can accept a word (= !pend_full while out of reset).
- ser_out  output  1  serial bit stream.
- ser_valid  output  1  `ser_out` carries a word bit this cycle.
- word_done  output  1  high during the cycle the last bit (bit 0) of a word is on `ser_out`.

## Operation
- Load fires on a rising edge when `load_valid && load_ready` are both high.
- Registers:
  - `shreg` [WIDTH-1:0], the active word.
  - `cnt` [$clog2(WIDTH)-1:0], the bit index, 0 to WIDTH-1.
  - `pend` [WIDTH-1:0] and `pend_full`, the one-entry buffer.
  - `state` ∈ {IDLE, SHIFT}.
- `ser_out` = `shreg[WIDTH-1]` in SHIFT, IDLE_BIT in IDLE.
- `ser_valid` = (state == SHIFT).
- `word_done` = SHIFT && cnt == WIDTH-1.
- All outputs are decoded from registers only; there is no combinational path from inputs.
- IDLE:
  - `pend_full` is always 0.
  - On a load: shreg ← load_data, cnt ← 0, go to SHIFT.
- SHIFT, cnt < WIDTH-1:
  - Shift `shreg` left by 1 and increment `cnt`.
  - On a load: pend ← load_data, pend_full ← 1.
- SHIFT, cnt == WIDTH-1 (last bit):
  - If pend_full: shreg ← pend, pend_full ← 0, cnt ← 0, stay in SHIFT. No load can fire on this edge because load_ready = 0.
  - Else, on a load: shreg ← load_data directly, cnt ← 0, stay in SHIFT.
  - Else: go to IDLE.
- `load_data` is sampled only on the firing edge; later changes to it have no effect.
- Holding `load_valid` low mid-word has no effect; the current word always completes.

## Timing
- Reset (rst = 0, asynchronous):
  - state = IDLE, shreg = 0, cnt = 0, pend = 0, pend_full = 0.
  - Outputs: ser_out = IDLE_BIT, ser_valid = 0, word_done = 0.
  - load_ready is forced to 0 while rst is low and is 1 from the first cycle after release.
- Reset mid-word discards both the active and the pending word. No `word_done` pulse is generated.
- Latency: a load firing at edge k puts bit WIDTH-1 on `ser_out` in the cycle after edge k.
  - Bit i appears in the cycle after edge k + (WIDTH-1-i).
  - `word_done` is high in the cycle after edge k + WIDTH-1.
- Throughput: with `load_valid` held high, words stream gaplessly at WIDTH cycles per word, and `ser_valid` stays high continuously.
- Back-pressure: `load_ready` drops the cycle after the pending buffer fills. It rises again the cycle after that word moves into `shreg`.
- Simultaneous last bit + load with an empty buffer: the new word's MSB follows the old word's bit 0 with no gap and without passing through `pend`.
- A word is never dropped or duplicated. A load is accepted only when `load_ready` is high.

## Test plan
- Reset then idle (WIDTH=8, IDLE_BIT=0): hold rst low for 2 cycles, then release.
  - During reset: ser_out = 0, ser_valid = 0, load_ready = 0.
  - After release: load_ready = 1, ser_out stays 0.
- Single word 8'hB0 loaded at edge k:
  - ser_out = 1,0,1,1,0,0,0,0 in the cycles after edges k through k+7, with ser_valid = 1 throughout.
  - word_done is high only in the 8th cycle.
  - The block is back in IDLE (ser_valid = 0) after edge k+8.
- Back-to-back, load_valid held high with 8'hB0 then 8'hBB:
  - 16 consecutive valid bits 1011_0000_1011_1011 with no gap.
  - load_ready is low while the second word waits in `pend`.
  - word_done pulses exactly twice, 8 cycles apart.
- Load offered on the last bit with an empty buffer: the second word's MSB appears in the very next cycle, and pend_full never goes to 1.
- Back-pressure: offer 3 words continuously.
  - The third word is accepted only when load_ready returns to 1.
  - Output order equals input order, 24 valid bits total.
- Reset mid-word: drop rst low at bit 3 of word 1 while word 2 is pending.
  - Outputs reach their reset values immediately (asynchronously).
  - After release nothing is emitted; the next load starts cleanly from its MSB.
